// File: rtl/riscv_cache_pkg.sv
// Shared constants for the MEM-stage data cache: default geometry,
// derived address-field widths and the controller state encodings.
package riscv_cache_pkg;

    localparam int DEF_NUM_LINES      = 64;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_ADDR_W         = 32;

    // Address split for the default geometry: byte | word | index | tag
    localparam int OFF_W = $clog2(DEF_WORDS_PER_LINE);
    localparam int IDX_W = $clog2(DEF_NUM_LINES);
    localparam int TAG_W = DEF_ADDR_W - 2 - OFF_W - IDX_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

endpackage

// File: rtl/dcache_array.sv
// Tag and data storage for the direct-mapped cache. Reads are
// asynchronous so a load hit returns data in the same cycle; writes are
// one word (and optionally the tag) per clock. Valid bits live in the
// controller so they can be cleared by reset; this storage is not reset.
module dcache_array #(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 22
) (
    input  logic                              clk,
    input  logic [$clog2(NUM_LINES)-1:0]      idx,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_word,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic [31:0]                       rd_data,
    input  logic                              we_data,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_word,
    input  logic [31:0]                       wr_data,
    input  logic                              we_tag,
    input  logic [TAG_W-1:0]                  wr_tag
);

    logic [TAG_W-1:0] tag_mem  [NUM_LINES];
    logic [31:0]      data_mem [NUM_LINES][WORDS_PER_LINE];

    assign rd_tag  = tag_mem[idx];
    assign rd_data = data_mem[idx][rd_word];

    // Single-word data write and tag write, both on the same line index
    always_ff @(posedge clk) begin
        if (we_data) begin
            data_mem[idx][wr_word] <= wr_data;
        end
        if (we_tag) begin
            tag_mem[idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// for the MEM stage. Holds the pipeline with StallCache while a refill or
// a write-through is outstanding on the req/ack memory port.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | serve load hits combinationally, launch misses/stores
//   ST_REFILL | fetch the whole line word by word, then mark it valid
//   ST_WRITE  | write one word through to memory, update line on hit
module dcache_ctrl
    import riscv_cache_pkg::*;
#(
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallCache,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int W_OFF = $clog2(WORDS_PER_LINE);
    localparam int W_IDX = $clog2(NUM_LINES);
    localparam int W_TAG = ADDR_W - 2 - W_OFF - W_IDX;
    localparam logic [W_OFF-1:0] LAST_WORD = W_OFF'(WORDS_PER_LINE - 1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [NUM_LINES-1:0] valid;
    logic [W_OFF-1:0]     cnt;
    logic [ADDR_W-3:0]    waddr_q;
    logic [31:0]          wdata_q;

    logic [ADDR_W-3:0]    look_waddr;
    logic [W_OFF-1:0]     look_word;
    logic [W_IDX-1:0]     look_idx;
    logic [W_TAG-1:0]     look_tag;
    logic [W_TAG-1:0]     rd_tag;
    logic [31:0]          rd_data;
    logic                 hit;
    logic                 is_store;
    logic                 is_load;
    logic                 last_ack;

    logic                 arr_we_data;
    logic                 arr_we_tag;
    logic [W_OFF-1:0]     arr_word;
    logic [31:0]          arr_wdata;

    logic [1:0]           unused_lsb;

    assign unused_lsb = ALUResultM[1:0];

    // While a transaction is outstanding the lookup follows the latched
    // address, so the memory side never depends on the pipeline holding
    // ALUResultM perfectly still.
    assign look_waddr = (state == ST_IDLE) ? ALUResultM[ADDR_W-1:2] : waddr_q;
    assign look_word  = look_waddr[W_OFF-1:0];
    assign look_idx   = look_waddr[W_OFF +: W_IDX];
    assign look_tag   = look_waddr[ADDR_W-3 -: W_TAG];

    assign hit      = valid[look_idx] && (rd_tag == look_tag);
    assign is_store = MemWriteM;
    assign is_load  = MemReadM & ~MemWriteM;
    assign last_ack = (state == ST_REFILL) && mem_ack && (cnt == LAST_WORD);

    assign arr_we_data = ((state == ST_REFILL) && mem_ack) ||
                         ((state == ST_WRITE) && mem_ack && hit);
    assign arr_we_tag  = last_ack;
    assign arr_word    = (state == ST_REFILL) ? cnt : look_word;
    assign arr_wdata   = (state == ST_REFILL) ? mem_rdata : wdata_q;

    dcache_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (W_TAG)
    ) u_array (
        .clk     (clk),
        .idx     (look_idx),
        .rd_word (look_word),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we_data (arr_we_data),
        .wr_word (arr_word),
        .wr_data (arr_wdata),
        .we_tag  (arr_we_tag),
        .wr_tag  (look_tag)
    );

    // Next-state decode; a store wins over a simultaneous load
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (is_store) begin
                    state_nxt = ST_WRITE;
                end else if (is_load && !hit) begin
                    state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (last_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transaction bookkeeping: latched address/data, word counter, valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            valid   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_store || (is_load && !hit)) begin
                        waddr_q <= ALUResultM[ADDR_W-1:2];
                        wdata_q <= WriteDataM;
                        cnt     <= '0;
                    end
                    // The victim line is invalidated up front so an
                    // abandoned refill can never leave a half-written
                    // line looking valid under its old tag.
                    if (is_load && !hit) begin
                        valid[look_idx] <= 1'b0;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (last_ack) begin
                        valid[look_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pipeline and memory-port outputs
    always_comb begin
        ReadDataM  = '0;
        StallCache = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            ST_IDLE: begin
                StallCache = ~rst & (is_store | (is_load & ~hit));
                if (is_load && hit) begin
                    ReadDataM = rd_data;
                end
            end
            ST_REFILL: begin
                StallCache = 1'b1;
                mem_req    = 1'b1;
                mem_addr   = {waddr_q[ADDR_W-3:W_OFF], cnt, 2'b00};
            end
            ST_WRITE: begin
                StallCache = ~mem_ack;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {waddr_q, 2'b00};
                mem_wdata  = wdata_q;
            end
            default: ;
        endcase
    end

endmodule
